down_counter_timer: RTL
=======================

# down_counter_timer

Loadable down-counting timer with a prescaler, pause and abort. It runs in one-shot or auto-reload mode. It counts in the opposite direction to the team's free-running up counter. Control logic uses it to time delays and periodic events. It reports a one-cycle `done` pulse each time the count reaches zero.

## Interface
- `WIDTH`, 4, counter width in bits (≥2)
- `PRESCALE`, 1, clock cycles per decrement (≥1); prescaler width is clog2(PRESCALE), minimum 1 bit
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-low reset
- `start`  input  1  load `load_val` and begin counting (level sampled each edge)
- `load_val`  input  WIDTH  start value, unsigned
- `auto_reload`  input  1  mode select, latched on accepted `start`
- `pause`  input  1  freeze count and prescaler while high
- `abort`  input  1  return to IDLE and clear count
- `out`  output  WIDTH  current count (registered)
- `busy`  output  1  high in RUN or HOLD
- `done`  output  1  one-cycle pulse when `out` transitions 1→0 (registered)

## Operation
- Reset (`rst`=0, asynchronous): state=IDLE, `out`=0, prescaler=0, reload register=0, latched mode=0, `busy`=0, `done`=0.
- States:
  - IDLE: `out` holds its value.
  - RUN: the prescaler counts 0..PRESCALE-1. A tick occurs when the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - HOLD: everything is frozen.
- Per-edge priority is abort > start > pause > tick.
- `abort`=1, any state: go to IDLE, `out`←0, prescaler←0, `done`←0.
- `start`=1, any state (restart allowed):
  - `out`←`load_val`, reload register←`load_val`, mode←`auto_reload`, prescaler←0, go to RUN.
  - If `load_val`=0: stay or go to IDLE, `out`←0, `done` pulses on the next edge. Mode is ignored.
- RUN with `pause`=1: go to HOLD with no tick that cycle. HOLD with `pause`=0: go to RUN and resume from the frozen prescaler value.
- Tick in RUN:
  - `out`>1: `out`←`out`−1.
  - `out`=1: `out`←0, `done`←1. In one-shot mode go to IDLE; in reload mode stay in RUN.
  - `out`=0 (reload mode only): `out`←reload register.
- `done` is 0 in every cycle except the pulse cycles above.
- `busy` = (state≠IDLE), decoded directly from the state register.
- Arithmetic: unsigned WIDTH-bit values. `out` never underflows, and a decrement from 0 never occurs. `load_val`=2^WIDTH−1 is legal.
- `load_val` and `auto_reload` are only used on an accepted `start`. Later changes have no effect.

## Timing
- `start` accepted at edge k: `out`=`load_val` and `busy`=1 after edge k.
- First decrement happens at edge k+PRESCALE. Each later decrement follows PRESCALE cycles after the previous one, excluding HOLD cycles.
- One-shot, `load_val`=N≥1: `done`=1 and `out`=0 after edge k+N·PRESCALE. `busy` falls on the same edge. `done` returns to 0 one edge later.
- Reload mode: period is (N+1)·PRESCALE cycles. The sequence is N…1,0,N… and `done` pulses once per period.
- Each HOLD cycle delays all subsequent events by exactly one cycle.
- `start` and `abort` on the same edge: abort wins, giving IDLE with `out`=0.
- `start` and `pause` on the same edge: start wins, giving RUN with the prescaler at 0. A `pause` still high on the next edge enters HOLD.
- Reset mid-run: outputs go to their reset values immediately, without waiting for `clk`. After release, the block waits in IDLE for `start`.

## Test plan
- WIDTH=4, PRESCALE=1, one-shot: start with `load_val`=5 at edge 0. Required: `out`=5,4,3,2,1,0 after edges 0..5. `done`=1 only after edge 5. `busy` is 1 after edges 0–4 and 0 after edge 5.
- Reload mode, `load_val`=2, PRESCALE=1: `out`=2,1,0,2,1,0,… `done` pulses after edges 2, 5, 8. `busy` stays 1.
- PRESCALE=3, `load_val`=2, one-shot: `out` changes after edges 3 and 6. `done` after edge 6 only.
- Pause: `load_val`=4, PRESCALE=1, `pause`=1 for 3 cycles starting after `out`=3. Required: `out` holds 3 for those 3 cycles, then resumes. `done` is 3 cycles later than the unpaused run (edge 7).
- Priority and edges:
  - `start`+`abort` together → IDLE, `out`=0.
  - Restart with `load_val`=9 while `out`=2 → `out`=9 next edge, no `done`.
  - `load_val`=0 → `done` one cycle after start, `busy`=0 throughout.
- Async reset asserted mid-count (`out`=3) between clock edges: `out`=0, `busy`=0, `done`=0 immediately. No activity after release until `start`.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with prescaler, pause and abort.
// Runs one-shot or auto-reload and pulses done on each 1->0 transition of out.
module down_counter_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PMAX    = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    presc_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             mode_reg;
    logic             zero_pend_reg;
    logic             done_reg;

    assign out  = count_reg;
    assign done = done_reg;
    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            count_reg     <= '0;
            reload_reg    <= '0;
            mode_reg      <= 1'b0;
            zero_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // A zero-length start reports done one edge after it is accepted.
            done_reg      <= zero_pend_reg;
            zero_pend_reg <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                count_reg <= '0;
                presc_reg <= '0;
                done_reg  <= 1'b0;
            end else if (start) begin
                presc_reg  <= '0;
                reload_reg <= load_val;
                mode_reg   <= auto_reload;
                if (load_val == '0) begin
                    state_reg     <= IDLE;
                    count_reg     <= '0;
                    zero_pend_reg <= 1'b1;
                end else begin
                    state_reg <= RUN;
                    count_reg <= load_val;
                end
            end else if (state_reg != IDLE) begin
                if (pause) begin
                    state_reg <= HOLD;
                end else begin
                    // Leaving HOLD counts as a running cycle so each hold cycle costs exactly one.
                    state_reg <= RUN;
                    if (presc_reg == PMAX) begin
                        presc_reg <= '0;
                        if (count_reg > ONE) begin
                            count_reg <= count_reg - ONE;
                        end else if (count_reg == ONE) begin
                            count_reg <= '0;
                            done_reg  <= 1'b1;
                            if (!mode_reg) begin
                                state_reg <= IDLE;
                            end
                        end else if (mode_reg) begin
                            count_reg <= reload_reg;
                        end
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
            end
        end
    end

endmodule
